// File: rtl/game_pkg.sv
// Shared encodings, state set, screen geometry and round-rule helpers for the
// cat/dog/chicken game round sequencer.
package game_pkg;

    localparam logic [2:0] CHOICE_CAT     = 3'b001;
    localparam logic [2:0] CHOICE_DOG     = 3'b010;
    localparam logic [2:0] CHOICE_CHICKEN = 3'b100;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [7:0] P1_SPR_X0 = 8'd16;
    localparam logic [7:0] P2_SPR_X0 = 8'd112;
    localparam logic [6:0] SPR_Y0    = 7'd40;

    typedef enum logic [3:0] {
        IDLE,
        LATCH,
        CLEAR,
        REQ_P1,
        WAIT_P1,
        REQ_P2,
        WAIT_P2,
        SCORE,
        SHOW,
        GAME_OVER
    } state_e;

    typedef enum logic [1:0] {
        RES_TIE = 2'b00,
        RES_P1  = 2'b01,
        RES_P2  = 2'b10
    } result_e;

    // Anything that is not a clean one-hot pick is played as cat.
    function automatic logic [2:0] sanitize_choice(input logic [2:0] c);
        case (c)
            CHOICE_CAT, CHOICE_DOG, CHOICE_CHICKEN: return c;
            default:                                return CHOICE_CAT;
        endcase
    endfunction

    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        return (a == CHOICE_DOG     && b == CHOICE_CAT)     ||
               (a == CHOICE_CAT     && b == CHOICE_CHICKEN) ||
               (a == CHOICE_CHICKEN && b == CHOICE_DOG);
    endfunction

    function automatic result_e round_winner(input logic [2:0] p1, input logic [2:0] p2);
        if (p1 == p2)       return RES_TIE;
        else if (beats(p1, p2)) return RES_P1;
        else                return RES_P2;
    endfunction

endpackage

// File: rtl/screen_scan.sv
// Raster scan over the full screen: x inner, y outer, one pixel per cycle.
// start_i arms the scan from (0,0); done_o is high on the last pixel.
module screen_scan
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       done_o
);

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       active_q, active_d;
    logic       last_px;

    assign last_px = (x_q == 8'(SCREEN_W - 1)) && (y_q == 7'(SCREEN_H - 1));

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        if (start_i) begin
            x_d      = '0;
            y_d      = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (last_px) begin
                x_d      = '0;
                y_d      = '0;
                active_d = 1'b0;
            end else if (x_q == 8'(SCREEN_W - 1)) begin
                x_d = '0;
                y_d = y_q + 7'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = active_q && last_px;

endmodule

// File: rtl/game_round_sequencer.sv
// Round sequencer: latches both picks, clears the screen, draws both sprites via
// the external sprite engine, scores the round and holds the result on screen.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned WIN_SCORE   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] p1_choice,
    input  logic [2:0] p2_choice,
    output logic       spr_start,
    output logic [2:0] spr_sel,
    output logic [7:0] spr_x0,
    output logic [6:0] spr_y0,
    input  logic       spr_done,
    input  logic [7:0] spr_x,
    input  logic [6:0] spr_y,
    input  logic [2:0] spr_colour,
    input  logic       spr_plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] result,
    output logic       busy
);

    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic        go_q;
    logic [2:0]  p1_q, p1_d, p2_q, p2_d;
    logic [3:0]  score1_q, score1_d, score2_q, score2_d;
    result_e     result_q, result_d;
    logic [31:0] hold_q, hold_d;

    logic        go_rise;
    logic        scan_start;
    logic        scan_done;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    result_e     winner;

    assign go_rise = go && !go_q;
    assign winner  = round_winner(p1_q, p2_q);

    screen_scan u_scan (
        .clk     (clk),
        .reset   (reset),
        .start_i (scan_start),
        .x_o     (scan_x),
        .y_o     (scan_y),
        .done_o  (scan_done)
    );

    always_comb begin
        state_d    = state_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        result_d   = result_q;
        hold_d     = hold_q;
        scan_start = 1'b0;

        case (state_q)
            IDLE: if (go_rise) state_d = LATCH;
            GAME_OVER: begin
                if (go_rise) begin
                    state_d  = LATCH;
                    score1_d = '0;
                    score2_d = '0;
                end
            end
            LATCH: begin
                p1_d       = sanitize_choice(p1_choice);
                p2_d       = sanitize_choice(p2_choice);
                scan_start = 1'b1;
                state_d    = CLEAR;
            end
            CLEAR:   if (scan_done) state_d = REQ_P1;
            REQ_P1:  state_d = WAIT_P1;
            WAIT_P1: if (spr_done) state_d = REQ_P2;
            REQ_P2:  state_d = WAIT_P2;
            WAIT_P2: if (spr_done) state_d = SCORE;
            SCORE: begin
                result_d = winner;
                // Saturating increments keep a score from running past the match limit.
                if (winner == RES_P1 && score1_q < WIN) score1_d = score1_q + 4'd1;
                if (winner == RES_P2 && score2_q < WIN) score2_d = score2_q + 4'd1;
                hold_d   = '0;
                state_d  = SHOW;
            end
            SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = (score1_q == WIN || score2_q == WIN) ? GAME_OVER : IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            go_q     <= 1'b0;
            p1_q     <= CHOICE_CAT;
            p2_q     <= CHOICE_CAT;
            score1_q <= '0;
            score2_q <= '0;
            result_q <= RES_TIE;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            go_q     <= go;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            result_q <= result_d;
            hold_q   <= hold_d;
        end
    end

    // Sprite request fields are decoded from state so they stay put through the wait.
    always_comb begin
        spr_start = 1'b0;
        spr_sel   = '0;
        spr_x0    = '0;
        spr_y0    = '0;
        x         = '0;
        y         = '0;
        colour    = '0;
        plot      = 1'b0;
        case (state_q)
            CLEAR: begin
                x    = scan_x;
                y    = scan_y;
                plot = 1'b1;
            end
            REQ_P1, WAIT_P1: begin
                spr_start = (state_q == REQ_P1);
                spr_sel   = p1_q;
                spr_x0    = P1_SPR_X0;
                spr_y0    = SPR_Y0;
            end
            REQ_P2, WAIT_P2: begin
                spr_start = (state_q == REQ_P2);
                spr_sel   = p2_q;
                spr_x0    = P2_SPR_X0;
                spr_y0    = SPR_Y0;
            end
            default: ;
        endcase
        if (state_q == WAIT_P1 || state_q == WAIT_P2) begin
            x      = spr_x;
            y      = spr_y;
            colour = spr_colour;
            plot   = spr_plot;
        end
    end

    assign score1 = score1_q;
    assign score2 = score2_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE) && (state_q != GAME_OVER);

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench: a small reference model pushes expected sprite requests and
// round outcomes into queues that are popped as the sequencer produces them.
module tb_game_round_sequencer;

    localparam int unsigned HOLD = 4;
    localparam int unsigned WIN  = 2;

    logic       clk = 1'b0;
    logic       reset, go;
    logic [2:0] p1_choice, p2_choice;
    logic       spr_start, spr_done, spr_plot, plot, busy;
    logic [2:0] spr_sel, spr_colour, colour;
    logic [7:0] spr_x0, spr_x, x;
    logic [6:0] spr_y0, spr_y, y;
    logic [3:0] score1, score2;
    logic [1:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int m_s1 = 0;
    int m_s2 = 0;

    logic [17:0] req_q[$];
    logic [9:0]  res_q[$];

    always #10 clk = ~clk;

    game_round_sequencer #(.HOLD_CYCLES(HOLD), .WIN_SCORE(WIN)) dut (
        .clk(clk), .reset(reset), .go(go),
        .p1_choice(p1_choice), .p2_choice(p2_choice),
        .spr_start(spr_start), .spr_sel(spr_sel), .spr_x0(spr_x0), .spr_y0(spr_y0),
        .spr_done(spr_done), .spr_x(spr_x), .spr_y(spr_y),
        .spr_colour(spr_colour), .spr_plot(spr_plot),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .score1(score1), .score2(score2), .result(result), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] norm(input logic [2:0] c);
        return ($countones(c) == 1) ? c : 3'b001;
    endfunction

    function automatic logic [1:0] model_result(input logic [2:0] a, input logic [2:0] b);
        if (a == b) return 2'b00;
        if ((a == 3'b010 && b == 3'b001) || (a == 3'b001 && b == 3'b100) ||
            (a == 3'b100 && b == 3'b010)) return 2'b01;
        return 2'b10;
    endfunction

    // Act as the sprite engine for one request observed at the current negedge.
    task automatic serve_sprite(input int delay, input bit poke_go);
        logic [17:0] exp_req;
        logic [17:0] drv;
        exp_req = req_q.pop_front();
        check("spr_req", {spr_sel, spr_x0, spr_y0}, exp_req);
        @(negedge clk);
        check("spr_start_pulse", spr_start, 0);
        for (int i = 0; i < delay; i++) begin
            drv = 18'($urandom);
            {spr_x, spr_y, spr_colour} = drv[17:0];
            spr_plot = 1'b1;
            if (poke_go && i == 10) go = 1'b1;
            if (poke_go && i == 20) go = 1'b0;
            #1;
            check("passthru", {x, y, colour, plot}, {drv, 1'b1});
            check("no_restart", spr_start, 0);
            @(negedge clk);
        end
        check("spr_hold", {spr_sel, spr_x0, spr_y0}, exp_req);
        spr_done = 1'b1;
        @(negedge clk);
        spr_done = 1'b0;
        spr_plot = 1'b0;
    endtask

    task automatic run_round(input logic [2:0] c1, input logic [2:0] c2,
                             input int delay, input bit poke_go);
        logic [2:0] n1, n2;
        logic [1:0] er;
        int s1_start, s2_start, npix, order_err, ex, ey, cnt;
        logic [9:0] exp_res;

        n1 = norm(c1);
        n2 = norm(c2);
        if (m_s1 == WIN || m_s2 == WIN) begin
            m_s1 = 0;
            m_s2 = 0;
        end
        s1_start = m_s1;
        s2_start = m_s2;
        er = model_result(n1, n2);
        if (er == 2'b01 && m_s1 < WIN) m_s1++;
        if (er == 2'b10 && m_s2 < WIN) m_s2++;
        req_q.push_back({n1, 8'd16, 7'd40});
        req_q.push_back({n2, 8'd112, 7'd40});
        res_q.push_back({er, 4'(m_s1), 4'(m_s2)});

        p1_choice = c1;
        p2_choice = c2;
        go = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("busy_rise", busy, 1);
        check("start_scores", {score1, score2}, {4'(s1_start), 4'(s2_start)});
        go = 1'b0;

        npix = 0; order_err = 0; ex = 0; ey = 0; cnt = 0;
        while (!spr_start && cnt < 20000) begin
            @(negedge clk);
            cnt++;
            if (plot) begin
                if (x != 8'(ex) || y != 7'(ey) || colour != 3'b000) order_err++;
                npix++;
                ex++;
                if (ex == 160) begin
                    ex = 0;
                    ey++;
                end
            end
        end
        check("clear_plots", npix, 19200);
        check("clear_order", order_err, 0);
        check("req1_seen", spr_start, 1);
        if (!spr_start) return;
        serve_sprite(delay, poke_go);

        cnt = 0;
        while (!spr_start && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("req2_seen", spr_start, 1);
        if (!spr_start) return;
        serve_sprite(0, 1'b0);

        cnt = 0;
        while (busy && cnt < int'(HOLD) + 10) begin
            cnt++;
            @(negedge clk);
        end
        check("show_len", cnt, HOLD + 1);
        exp_res = res_q.pop_front();
        check("result", result, exp_res[9:8]);
        check("scores", {score1, score2}, exp_res[7:0]);
    endtask

    initial begin
        int bad;
        reset = 1'b1; go = 1'b0; p1_choice = 3'b001; p2_choice = 3'b001;
        spr_done = 1'b0; spr_x = '0; spr_y = '0; spr_colour = '0; spr_plot = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_spr_start", spr_start, 0);
        check("rst_scores", {score1, score2}, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_round(3'b010, 3'b001, 0, 1'b0);    // dog beats cat
        run_round(3'b100, 3'b100, 0, 1'b0);    // tie
        run_round(3'b001, 3'b010, 100, 1'b1);  // P2 wins, slow engine, stray go
        run_round(3'b011, 3'b100, 0, 1'b0);    // invalid P1 plays cat, ends match

        repeat (20) @(negedge clk);
        check("game_over_idle", busy, 0);
        check("game_over_scores", {score1, score2}, {4'(m_s1), 4'(m_s2)});

        // New match from game over, then reset in the middle of the clear.
        go = 1'b1;
        @(negedge clk);
        check("rematch_busy", busy, 1);
        check("rematch_zeroed", {score1, score2}, 0);
        go = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_clear_plot", plot, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_plot", plot, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_scores", {score1, score2}, 0);
        reset = 1'b0;
        spr_done = 1'b1;
        @(negedge clk);
        spr_done = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || spr_start || plot) bad++;
        end
        check("stray_done_ignored", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_round_sequencer.md
GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, result display time in clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter WIN_SCORE, default 5, points that end a match.
REQ-003 SHALL have ports, in order:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- go  in  1  user start, level; acted on at its rising edge
- p1_choice  in  3  one-hot: cat 001, dog 010, chicken 100
- p2_choice  in  3  same encoding
- spr_start  out  1  one-cycle sprite draw request
- spr_sel  out  3  one-hot sprite to draw
- spr_x0  out  8  sprite origin x
- spr_y0  out  7  sprite origin y
- spr_done  in  1  one-cycle sprite engine completion
- spr_x  in  8  sprite engine pixel x
- spr_y  in  7  sprite engine pixel y
- spr_colour  in  3  sprite engine pixel colour
- spr_plot  in  1  sprite engine write strobe
- x  out  8  VGA adapter x
- y  out  7  VGA adapter y
- colour  out  3  VGA adapter colour
- plot  out  1  VGA adapter write strobe
- score1  out  4  player 1 points
- score2  out  4  player 2 points
- result  out  2  last round: 00 tie, 01 P1, 10 P2
- busy  out  1  high in every state except IDLE and GAME_OVER

Function
REQ-004 SHALL register go and detect its rising edge; edges outside IDLE/GAME_OVER are ignored.
REQ-005 SHALL implement states IDLE, LATCH, CLEAR, REQ_P1, WAIT_P1, REQ_P2, WAIT_P2, SCORE, SHOW, GAME_OVER.
REQ-006 IDLE -> LATCH on the cycle after a go edge; GAME_OVER -> LATCH on a go edge, also zeroing score1/score2 in that cycle.
REQ-007 LATCH SHALL capture both choices for one cycle; a non-one-hot choice SHALL be captured as cat (001).
REQ-008 CLEAR SHALL write black (000) to every pixel, x 0..159 inner and y 0..119 outer, one per cycle with plot=1, exactly 19200 cycles, then go to REQ_P1.
REQ-009 REQ_P1 SHALL pulse spr_start for one cycle with spr_sel = P1 choice, spr_x0=16, spr_y0=40; REQ_P2 uses P2 choice, spr_x0=112, spr_y0=40.
REQ-010 spr_sel/spr_x0/spr_y0 SHALL hold stable from the request cycle until spr_done is accepted.
REQ-011 spr_done SHALL be accepted only in WAIT_P1/WAIT_P2 (earliest one cycle after spr_start); WAIT_P1 -> REQ_P2, WAIT_P2 -> SCORE.
REQ-012 x/y/colour/plot SHALL come from the clear scan in CLEAR, pass spr_* through combinationally in WAIT_P1/WAIT_P2, else plot=0.
REQ-013 Round rules: dog beats cat, cat beats chicken, chicken beats dog; equal choices tie.
REQ-014 SCORE SHALL, in one cycle, set result and increment the winner's score by 1; a tie changes no score.
REQ-015 SHOW SHALL last exactly HOLD_CYCLES cycles, then go to GAME_OVER if either score equals WIN_SCORE, else IDLE.
REQ-016 Scores SHALL never exceed WIN_SCORE; no wrap-around.

Reset
REQ-017 With reset high at a clk edge, next cycle: state IDLE, score1=score2=0, result=00, spr_start=0, plot=0, busy=0, scan/hold counters 0, go edge register cleared.
REQ-018 Reset mid-operation SHALL abandon the round; a pending sprite handshake is dropped, and a later spr_done in IDLE is ignored.

Structure
REQ-019 Package game_pkg SHALL hold choice encodings, the state enum, screen width/height (160/120) and sprite origin constants.
REQ-020 The clear scan SHALL be sub-module screen_scan (x/y counter with start/done); the hold timer stays inline.

Verification
REQ-021 Reset, go edge, P1=dog, P2=cat, instant spr_done -> 19200 black plots, requests (010,16,40) then (001,112,40), result=01, score1=1.
REQ-022 P1=chicken, P2=chicken -> result=00, scores unchanged, IDLE after HOLD_CYCLES.
REQ-023 P1=011 (invalid), P2=chicken -> P1 treated as cat, result=01.
REQ-024 Five P2 wins (HOLD_CYCLES=4) -> score2=5, GAME_OVER, busy=0; next go zeroes scores and starts a round.
REQ-025 go edge during WAIT_P1, spr_done delayed 100 cycles -> no restart, spr_* passed through to x/y/colour/plot.
REQ-026 reset asserted mid-CLEAR -> plot=0 next cycle, scores 0, IDLE; stray spr_done ignored.
